// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores on the data-memory port and returns one writeback bundle per instruction.
// Non-memory/misaligned bundles emit the next cycle; ex_ready stays low while a dmem transaction is outstanding.
package mem_stage_pkg;
  typedef enum logic [1:0] {
    RS_ALU = 2'd0,
    RS_MEM = 2'd1,
    RS_PC4 = 2'd2,
    RS_IMM = 2'd3
  } result_src_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_ex_valid,
  output logic        o_ex_ready,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_reg_write,
  input  result_src_t i_result_src,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_result,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_rd2,
  input  logic [31:0] i_pc_cur,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_wstrb,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic        o_wb_reg_write,
  output logic [4:0]  o_wb_rd,
  output result_src_t o_wb_result_src,
  output logic [31:0] o_wb_alu_result,
  output logic [31:0] o_wb_read_data,
  output logic [31:0] o_wb_pc_cur,
  output logic        o_wb_misaligned,
  output logic        o_wb_bus_error
);

  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [CW-1:0] LIM_M1 = CW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic        r_we, r_reg_write;
  logic [2:0]  r_f3;
  logic [31:0] r_alu, r_pc, r_wdata;
  logic [4:0]  r_rd;
  logic [3:0]  r_wstrb;
  result_src_t r_result_src;

  logic        r_wb_valid, r_wb_reg_write, r_wb_misaligned, r_wb_bus_error;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_alu_result, r_wb_read_data, r_wb_pc_cur;
  result_src_t r_wb_result_src;

  logic        w_in_mem, w_in_mis, w_capture, w_from_in;
  logic        w_emit, w_emit_mis, w_emit_berr, w_emit_ld;
  logic [31:0] w_st_wdata, w_ld_data;
  logic [3:0]  w_st_wstrb;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic        w_src_reg_write;
  logic [4:0]  w_src_rd;
  logic [31:0] w_src_alu, w_src_pc;
  result_src_t w_src_result_src;

  assign w_in_mem = i_mem_read | i_mem_write;
  // funct3[1:0]: 00 byte, 01 half, anything wider is treated as a word access
  assign w_in_mis = w_in_mem &
                    (((i_funct3[1:0] == 2'b01) & i_alu_result[0]) |
                     (i_funct3[1] & (i_alu_result[1:0] != 2'b00)));

  always_comb begin
    w_st_wdata = i_rd2;
    w_st_wstrb = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        w_st_wdata = {4{i_rd2[7:0]}};
        w_st_wstrb = 4'b0001 << i_alu_result[1:0];
      end
      2'b01: begin
        w_st_wdata = {2{i_rd2[15:0]}};
        w_st_wstrb = i_alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_st_wdata = i_rd2;
        w_st_wstrb = 4'b1111;
      end
    endcase
    if (!i_mem_write) begin
      w_st_wstrb = 4'b0000;
    end
  end

  always_comb begin
    w_ld_byte = i_dmem_rdata[{r_alu[1:0], 3'b000} +: 8];
    w_ld_half = i_dmem_rdata[{r_alu[1], 4'b0000} +: 16];
    case (r_f3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_data = {24'h000000, w_ld_byte};
      3'b101:  w_ld_data = {16'h0000, w_ld_half};
      default: w_ld_data = i_dmem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_capture   = 1'b0;
    w_emit      = 1'b0;
    w_emit_mis  = 1'b0;
    w_emit_berr = 1'b0;
    w_emit_ld   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_ex_valid) begin
          w_capture = 1'b1;
          if (!w_in_mem) begin
            w_emit = 1'b1;
          end else if (w_in_mis) begin
            w_emit     = 1'b1;
            w_emit_mis = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // a granted store completes even in the last allowed cycle; a granted load needs RESP time
        if (i_dmem_gnt && r_we) begin
          w_emit      = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LIM_M1) begin
          w_emit      = 1'b1;
          w_emit_berr = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (i_dmem_gnt) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (i_dmem_rvalid) begin
          w_emit      = 1'b1;
          w_emit_ld   = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LIM_M1) begin
          w_emit      = 1'b1;
          w_emit_berr = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bundles that complete in IDLE take their fields straight from the execute inputs
  assign w_from_in        = (r_state == S_IDLE);
  assign w_src_reg_write  = w_from_in ? i_reg_write  : r_reg_write;
  assign w_src_rd         = w_from_in ? i_rd         : r_rd;
  assign w_src_alu        = w_from_in ? i_alu_result : r_alu;
  assign w_src_pc         = w_from_in ? i_pc_cur     : r_pc;
  assign w_src_result_src = w_from_in ? i_result_src : r_result_src;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we         <= 1'b0;
      r_reg_write  <= 1'b0;
      r_f3         <= 3'b000;
      r_alu        <= '0;
      r_pc         <= '0;
      r_rd         <= '0;
      r_wdata      <= '0;
      r_wstrb      <= 4'b0000;
      r_result_src <= RS_ALU;
    end else if (w_capture) begin
      r_we         <= i_mem_write;
      r_reg_write  <= i_reg_write;
      r_f3         <= i_funct3;
      r_alu        <= i_alu_result;
      r_pc         <= i_pc_cur;
      r_rd         <= i_rd;
      r_wdata      <= w_st_wdata;
      r_wstrb      <= w_st_wstrb;
      r_result_src <= i_result_src;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_rd         <= '0;
      r_wb_result_src <= RS_ALU;
      r_wb_alu_result <= '0;
      r_wb_read_data  <= '0;
      r_wb_pc_cur     <= '0;
      r_wb_misaligned <= 1'b0;
      r_wb_bus_error  <= 1'b0;
    end else begin
      r_wb_valid <= w_emit;
      if (w_emit) begin
        r_wb_reg_write  <= w_src_reg_write & ~w_emit_mis & ~w_emit_berr;
        r_wb_rd         <= w_src_rd;
        r_wb_result_src <= w_src_result_src;
        r_wb_alu_result <= w_src_alu;
        r_wb_read_data  <= w_emit_ld ? w_ld_data : 32'h0000_0000;
        r_wb_pc_cur     <= w_src_pc;
        r_wb_misaligned <= w_emit_mis;
        r_wb_bus_error  <= w_emit_berr;
      end
    end
  end

  assign o_ex_ready      = (r_state == S_IDLE);
  assign o_dmem_req      = (r_state == S_REQ);
  assign o_dmem_we       = (r_state == S_REQ) & r_we;
  assign o_dmem_addr     = {r_alu[31:2], 2'b00};
  assign o_dmem_wdata    = r_wdata;
  assign o_dmem_wstrb    = (r_state == S_REQ) ? r_wstrb : 4'b0000;

  assign o_wb_valid      = r_wb_valid;
  assign o_wb_reg_write  = r_wb_reg_write;
  assign o_wb_rd         = r_wb_rd;
  assign o_wb_result_src = r_wb_result_src;
  assign o_wb_alu_result = r_wb_alu_result;
  assign o_wb_read_data  = r_wb_read_data;
  assign o_wb_pc_cur     = r_wb_pc_cur;
  assign o_wb_misaligned = r_wb_misaligned;
  assign o_wb_bus_error  = r_wb_bus_error;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand sequences for reset/back-to-back, and random ops vs a reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_ready, mem_read, mem_write, reg_write;
  result_src_t result_src;
  logic [2:0]  funct3;
  logic [31:0] alu_result, rd2, pc_cur;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, wb_reg_write, wb_misaligned, wb_bus_error;
  logic [4:0]  wb_rd;
  result_src_t wb_result_src;
  logic [31:0] wb_alu_result, wb_read_data, wb_pc_cur;

  mem_stage #(.WAIT_LIMIT(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_ex_valid(ex_valid), .o_ex_ready(ex_ready),
    .i_mem_read(mem_read), .i_mem_write(mem_write), .i_reg_write(reg_write),
    .i_result_src(result_src), .i_funct3(funct3), .i_alu_result(alu_result),
    .i_rd(rd), .i_rd2(rd2), .i_pc_cur(pc_cur),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .o_dmem_wstrb(dmem_wstrb),
    .i_dmem_gnt(dmem_gnt), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_wb_valid(wb_valid), .o_wb_reg_write(wb_reg_write), .o_wb_rd(wb_rd),
    .o_wb_result_src(wb_result_src), .o_wb_alu_result(wb_alu_result),
    .o_wb_read_data(wb_read_data), .o_wb_pc_cur(wb_pc_cur),
    .o_wb_misaligned(wb_misaligned), .o_wb_bus_error(wb_bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mr, mw, rw;
    logic [2:0]  f3;
    logic [31:0] addr, d2, mdata;
    int          gd, rdl;
    logic        x_mis, x_berr, x_rw;
    logic [31:0] x_rdat, x_wdat;
    logic [3:0]  x_strb;
    int          x_lat;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mr, input logic mw, input logic rw, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] d2, input logic [31:0] mdata,
                              input int gd, input int rdl, input logic xm, input logic xb, input logic xr,
                              input logic [31:0] xrd, input logic [31:0] xwd, input logic [3:0] xs, input int xl);
    vec_t v;
    v.mr = mr; v.mw = mw; v.rw = rw; v.f3 = f3; v.addr = addr; v.d2 = d2; v.mdata = mdata;
    v.gd = gd; v.rdl = rdl; v.x_mis = xm; v.x_berr = xb; v.x_rw = xr;
    v.x_rdat = xrd; v.x_wdat = xwd; v.x_strb = xs; v.x_lat = xl;
    return v;
  endfunction

  // Reference: outcome of one instruction from the access size, alignment and memory response timing.
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    int     size, off, total;
    bit     mem;
    longint val, span;
    r = v;
    size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    off  = int'(v.addr % 4);
    mem  = v.mr || v.mw;
    r.x_mis = mem && (off % size != 0);
    r.x_berr = 1'b0; r.x_rdat = 0; r.x_wdat = 0; r.x_strb = 0;
    if (!mem || r.x_mis) begin
      r.x_lat = 1;
    end else if (v.mw) begin
      r.x_berr = (v.gd >= L);
      r.x_lat  = r.x_berr ? L + 1 : v.gd + 2;
      r.x_wdat = (size == 1) ? (v.d2 % 256) * 32'h0101_0101 :
                 (size == 2) ? (v.d2 % 65536) * 32'h0001_0001 : v.d2;
      r.x_strb = 4'(((1 << size) - 1) << off);
    end else begin
      total    = v.gd + 2 + v.rdl;
      r.x_berr = (total > L);
      r.x_lat  = r.x_berr ? L + 1 : total + 1;
      if (!r.x_berr) begin
        span = 64'sd1 << (8 * size);
        val  = (longint'(v.mdata) >> (8 * off)) % span;
        if (size < 4 && !v.f3[2] && val >= span / 2) val = val - span;
        r.x_rdat = 32'(val);
      end
    end
    r.x_rw = v.rw && !r.x_mis && !r.x_berr;
    return r;
  endfunction

  task automatic run_op(input string nm, input vec_t v);
    int k, gcnt, rcnt, busy_bad, hold_bad, req_cycles;
    bit seen, granted;
    logic [4:0]  rd_v;
    logic [31:0] pc_v;
    result_src_t rs_v;
    logic [68:0] req0, cur;
    rd_v = 5'($urandom);
    pc_v = $urandom;
    rs_v = result_src_t'($urandom_range(0, 3));
    k = 0;
    while (!ex_ready && k < 10) begin
      @(posedge clk); #1; k++;
    end
    ex_valid = 1'b1; mem_read = v.mr; mem_write = v.mw; reg_write = v.rw;
    funct3 = v.f3; alu_result = v.addr; rd2 = v.d2; rd = rd_v; pc_cur = pc_v;
    result_src = rs_v; dmem_rdata = v.mdata;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    k = 1; seen = 0; granted = 0; gcnt = 0; rcnt = 0;
    busy_bad = 0; hold_bad = 0; req_cycles = 0; req0 = '0;
    while (!seen && k <= 30) begin
      if (dmem_req) begin
        req_cycles++;
        cur = {dmem_we, dmem_addr, dmem_wstrb, dmem_wdata};
        if (req_cycles == 1) req0 = cur;
        else if (cur !== req0) hold_bad++;
      end
      if (wb_valid) begin
        seen = 1;
      end else begin
        if (ex_ready !== 1'b0 && (v.mr || v.mw) && !v.x_mis) busy_bad++;
        if (dmem_req) begin
          if (gcnt == v.gd) begin dmem_gnt = 1'b1; granted = 1; end
          else gcnt++;
        end else if (granted && v.mr) begin
          if (rcnt == v.rdl) dmem_rvalid = 1'b1;
          else rcnt++;
        end
        @(posedge clk); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        k++;
      end
    end
    chk({nm, " latency"}, 64'(seen ? k : 999), 64'(v.x_lat));
    chk({nm, " mis/berr/regw"}, 64'({wb_misaligned, wb_bus_error, wb_reg_write}),
        64'({v.x_mis, v.x_berr, v.x_rw}));
    chk({nm, " read_data"}, 64'(wb_read_data), 64'(v.x_rdat));
    chk({nm, " alu_result"}, 64'(wb_alu_result), 64'(v.addr));
    chk({nm, " rd/src/pc"}, 64'({wb_rd, wb_result_src, wb_pc_cur}), 64'({rd_v, rs_v, pc_v}));
    chk({nm, " ex_ready at wb"}, 64'(ex_ready), 64'(1));
    if ((v.mr || v.mw) && !v.x_mis) begin
      chk({nm, " req we/addr/strb"}, 64'({req0[68], req0[67:36], req0[35:32]}),
          64'({v.mw, v.addr[31:2], 2'b00, v.x_strb}));
      if (v.mw) chk({nm, " req wdata"}, 64'(req0[31:0]), 64'(v.x_wdat));
      chk({nm, " req held/busy"}, 64'({hold_bad, busy_bad}), 64'(0));
    end else begin
      chk({nm, " no dmem_req"}, 64'(req_cycles), 64'(0));
    end
    // A late rvalid after a timed-out load must not produce a bundle
    if (v.x_berr && v.mr) dmem_rvalid = 1'b1;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk({nm, " wb_valid pulse"}, 64'(wb_valid), 64'(0));
  endtask

  vec_t tbl[14];
  vec_t rv;
  int   cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; ex_valid = 0; mem_read = 0; mem_write = 0; reg_write = 0;
    result_src = RS_ALU; funct3 = 0; alu_result = 0; rd2 = 0; rd = 0; pc_cur = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;

    tbl[0]  = mk(0,0,1,3'b000,32'h5,  0,0,            0,0,  0,0,1,32'h0,        32'h0,        4'h0,1);
    tbl[1]  = mk(0,1,0,3'b010,32'h100,32'hDEADBEEF,0, 3,0,  0,0,0,32'h0,        32'hDEADBEEF, 4'hF,5);
    tbl[2]  = mk(1,0,1,3'b000,32'h103,0,32'h80FF0000, 0,0,  0,0,1,32'hFFFFFF80, 32'h0,        4'h0,3);
    tbl[3]  = mk(1,0,1,3'b100,32'h103,0,32'h80FF0000, 0,0,  0,0,1,32'h00000080, 32'h0,        4'h0,3);
    tbl[4]  = mk(0,1,0,3'b001,32'h102,32'h1234ABCD,0, 0,0,  0,0,0,32'h0,        32'hABCDABCD, 4'hC,2);
    tbl[5]  = mk(1,0,1,3'b010,32'h102,0,0,            0,0,  1,0,0,32'h0,        32'h0,        4'h0,1);
    tbl[6]  = mk(1,0,1,3'b001,32'h102,0,32'h80FF0000, 1,0,  0,0,1,32'hFFFF80FF, 32'h0,        4'h0,4);
    tbl[7]  = mk(1,0,1,3'b101,32'h100,0,32'h80FF8001, 0,1,  0,0,1,32'h00008001, 32'h0,        4'h0,4);
    tbl[8]  = mk(0,1,0,3'b000,32'h101,32'h000000A5,0, 0,0,  0,0,0,32'h0,        32'hA5A5A5A5, 4'h2,2);
    tbl[9]  = mk(1,0,1,3'b010,32'h104,0,32'h12345678, 0,2,  0,0,1,32'h12345678, 32'h0,        4'h0,5);
    tbl[10] = mk(1,0,1,3'b010,32'h108,0,32'h12345678, 1,2,  0,1,0,32'h0,        32'h0,        4'h0,5);
    tbl[11] = mk(1,0,1,3'b010,32'h200,0,32'hCAFEF00D, 0,99, 0,1,0,32'h0,        32'h0,        4'h0,5);
    tbl[12] = mk(0,1,1,3'b010,32'h300,32'h55AA55AA,0, 4,0,  0,1,0,32'h0,        32'h55AA55AA, 4'hF,5);
    tbl[13] = mk(0,1,1,3'b001,32'h101,32'h1,0,        0,0,  1,0,0,32'h0,        32'h0,        4'h0,1);

    repeat (2) @(posedge clk);
    #1;
    chk("in reset dmem_req/wb_valid", 64'({dmem_req, wb_valid}), 64'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("reset ex_ready", 64'(ex_ready), 64'(1));
    chk("reset dmem we/strb", 64'({dmem_req, dmem_we, dmem_wstrb}), 64'(0));
    chk("reset wb ctl", 64'({wb_valid, wb_reg_write, wb_misaligned, wb_bus_error, wb_rd, wb_result_src}), 64'(0));
    chk("reset wb data", 64'(wb_alu_result | wb_read_data | wb_pc_cur), 64'(0));

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i]);
    end

    // Back-to-back non-memory bundles at one per cycle
    ex_valid = 1'b1; mem_read = 0; mem_write = 0; reg_write = 1; alu_result = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b%0d valid/alu", i), 64'({wb_valid, wb_alu_result}), 64'({1'b1, 32'h10 + 32'(i)}));
      alu_result = 32'h11 + 32'(i);
    end
    ex_valid = 1'b0;
    @(posedge clk); #1;

    // Reset while a granted load waits in RESP
    ex_valid = 1'b1; mem_read = 1; mem_write = 0; reg_write = 1; funct3 = 3'b010; alu_result = 32'h40;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("rst-load dmem_req", 64'(dmem_req), 64'(1));
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    chk("rst-load in RESP ex_ready", 64'(ex_ready), 64'(0));
    reset_n = 1'b0;
    #1;
    chk("rst-load outputs cleared", 64'({wb_valid, dmem_req, wb_reg_write, wb_alu_result}), 64'(0));
    dmem_rvalid = 1'b1;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (wb_valid) cnt++;
    end
    chk("rst-load no wb_valid", 64'(cnt), 64'(0));
    run_op("rst ADD", mk(0,0,1,3'b000,32'h5,0,0,0,0, 0,0,1,32'h0,32'h0,4'h0,1));

    for (int i = 0; i < 200; i++) begin
      cnt = $urandom_range(0, 2);
      rv.mr = (cnt == 1); rv.mw = (cnt == 2); rv.rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: rv.f3 = 3'b000;
        1: rv.f3 = 3'b001;
        2: rv.f3 = 3'b010;
        3: rv.f3 = 3'b100;
        default: rv.f3 = 3'b101;
      endcase
      if (rv.mw) rv.f3[2] = 1'b0;
      rv.addr = $urandom; rv.d2 = $urandom; rv.mdata = $urandom;
      if ($urandom_range(0, 2) != 0) rv.addr[1:0] = 2'b00;
      rv.gd = $urandom_range(0, 4); rv.rdl = $urandom_range(0, 3);
      run_op($sformatf("rand%0d", i), model(rv));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
